// File: rtl/shift_exec_stage_pkg.sv
// Shared definitions for the shift execute stage: op encodings, widths,
// ALU flag bit positions and the registered payload layout.
package shift_exec_stage_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    typedef enum logic [1:0] {
        OP_SHL = 2'b00,
        OP_SHR = 2'b01,
        OP_ROL = 2'b10,
        OP_ASR = 2'b11
    } shift_op_e;

    // Bit positions match the ALU flag register.
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_W = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic [FLAG_W-1:0] flags;
    } shift_payload_t;

    function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = v[DATA_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_exec_stage_core.sv
// Combinational shift function: the left barrel shifter plus a bit-reversed
// second copy that supplies the right shifts and the rotate's wrap-around part.
module barrel_shl #(
    parameter int W  = 8,
    parameter int AW = 3
) (
    input  logic [W-1:0]  data_i,
    input  logic [AW-1:0] amt_i,
    output logic [W-1:0]  data_o
);
    logic [W-1:0] stage [AW+1];

    assign stage[0] = data_i;

    genvar gi;
    generate
        for (gi = 0; gi < AW; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage[gi+1] = amt_i[gi] ? (stage[gi] << SH) : stage[gi];
        end
    endgenerate

    assign data_o = stage[AW];
endmodule

module shift_core
    import shift_exec_stage_pkg::*;
(
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [AMT_W-1:0]  amt_i,
    output logic [DATA_W-1:0] result_o,
    output logic [FLAG_W-1:0] flags_o
);
    logic [DATA_W-1:0] rev_a;
    logic [DATA_W-1:0] shl_y;
    logic [DATA_W-1:0] rev_in;
    logic [AMT_W-1:0]  rev_amt;
    logic [DATA_W-1:0] rev_y;
    logic [DATA_W-1:0] right_y;
    logic [DATA_W-1:0] asr_mask;
    logic [AMT_W:0]    hi_idx;
    logic [AMT_W-1:0]  lo_idx;
    logic [DATA_W-1:0] result;
    logic              carry;

    assign rev_a = bit_reverse(a_i);

    barrel_shl #(.W(DATA_W), .AW(AMT_W)) u_shl_fwd (
        .data_i (a_i),
        .amt_i  (amt_i),
        .data_o (shl_y)
    );

    // For ROL the reversed path computes a >> (8-k) as (a >> 1) >> (7-k),
    // so k = 0 shifts everything out and the rotate degenerates to a.
    assign rev_in  = (op_i == OP_ROL) ? (rev_a << 1) : rev_a;
    assign rev_amt = (op_i == OP_ROL) ? ~amt_i : amt_i;

    barrel_shl #(.W(DATA_W), .AW(AMT_W)) u_shl_rev (
        .data_i (rev_in),
        .amt_i  (rev_amt),
        .data_o (rev_y)
    );

    assign right_y  = bit_reverse(rev_y);
    assign asr_mask = a_i[DATA_W-1] ? ~({DATA_W{1'b1}} >> amt_i) : '0;
    assign hi_idx   = (AMT_W+1)'(DATA_W) - {1'b0, amt_i};
    assign lo_idx   = amt_i - AMT_W'(1);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op_i)
            OP_SHL: begin
                result = shl_y;
                carry  = a_i[hi_idx[AMT_W-1:0]];
            end
            OP_SHR: begin
                result = right_y;
                carry  = a_i[lo_idx];
            end
            OP_ROL: begin
                result = shl_y | right_y;
                carry  = result[0];
            end
            OP_ASR: begin
                result = right_y | asr_mask;
                carry  = a_i[lo_idx];
            end
            default: ;
        endcase
        if (amt_i == '0) begin
            carry = 1'b0;
        end
    end

    assign result_o        = result;
    assign flags_o[FLAG_C] = carry;
    assign flags_o[FLAG_Z] = (result == '0);
    assign flags_o[FLAG_N] = result[DATA_W-1];
endmodule

// File: rtl/shift_exec_stage.sv
// Registered shift execute stage: output register plus one skid entry so that
// in_ready comes straight from a flop while still sustaining one op per cycle.
module shift_exec_stage
    import shift_exec_stage_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [AMT_W-1:0] in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_c,
    output logic             out_z,
    output logic             out_n
);
    stage_state_e   state_q, state_d;
    logic           in_ready_q, in_ready_d;
    shift_payload_t main_q, skid_q;
    shift_payload_t core_payload;
    logic           in_fire, out_fire;
    logic           load_main, load_skid, main_from_skid;

    shift_core u_core (
        .op_i     (in_op),
        .a_i      (in_a),
        .amt_i    (in_amt),
        .result_o (core_payload.result),
        .flags_o  (core_payload.flags)
    );

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = in_ready_q;
    assign in_fire   = in_valid & in_ready_q;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d   = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && !out_fire) begin
                    state_d   = ST_TWO;
                    load_skid = 1'b1;
                end else if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    state_d        = ST_ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush drops everything queued but leaves payload flops untouched.
        if (flush) begin
            state_d        = ST_EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            if (load_main) begin
                main_q <= core_payload;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= core_payload;
            end
        end
    end

    assign out_result = main_q.result;
    assign out_c      = main_q.flags[FLAG_C];
    assign out_z      = main_q.flags[FLAG_Z];
    assign out_n      = main_q.flags[FLAG_N];
endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed vectors, backpressure,
// streaming, flush, random traffic against a queue model, async reset.
module tb_shift_exec_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_op = 2'd0;
    logic [7:0] in_a = 8'd0;
    logic [2:0] in_amt = 3'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_result;
    logic       out_c, out_z, out_n;

    int checks = 0;
    int errors = 0;

    shift_exec_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_amt     (in_amt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_c      (out_c),
        .out_z      (out_z),
        .out_n      (out_n)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic. Returns {n, z, c, result[7:0]}.
    function automatic logic [10:0] ref_model(input logic [1:0] op, input logic [7:0] a,
                                              input logic [2:0] k);
        int ai, ki, r, c, sa;
        ai = int'(a);
        ki = int'(k);
        r  = 0;
        c  = 0;
        case (op)
            2'd0: begin r = (ai << ki) & 255; c = (ki != 0) ? (ai >> (8 - ki)) & 1 : 0; end
            2'd1: begin r = ai >> ki;         c = (ki != 0) ? (ai >> (ki - 1)) & 1 : 0; end
            2'd2: begin r = ((ai << ki) | (ai >> (8 - ki))) & 255; c = (ki != 0) ? r & 1 : 0; end
            default: begin
                sa = (ai >= 128) ? ai - 256 : ai;
                r  = (sa >>> ki) & 255;
                c  = (ki != 0) ? (ai >> (ki - 1)) & 1 : 0;
            end
        endcase
        return {(r >= 128), (r == 0), (c != 0), 8'(r)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] a,
                         input logic [2:0] k);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_amt   = k;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, in_ready, out_result, out_c, out_z, out_n} !== {1'b0, 1'b1, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL reset_state: got v=%b rdy=%b res=%h czn=%b%b%b, want v=0 rdy=1 res=00 czn=000",
                     out_valid, in_ready, out_result, out_c, out_z, out_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [11] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd0, 2'd2};
        logic [7:0]  t_a  [11] = '{8'h81, 8'h01, 8'h81, 8'h80, 8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h7F, 8'h01, 8'h01};
        logic [2:0]  t_k  [11] = '{3'd1, 3'd1, 3'd3, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7};
        logic [10:0] t_e  [11] = '{{3'b001, 8'h02}, {3'b011, 8'h00}, {3'b000, 8'h0C}, {3'b100, 8'hFF},
                                   {3'b000, 8'h5A}, {3'b000, 8'h5A}, {3'b000, 8'h5A}, {3'b000, 8'h5A},
                                   {3'b011, 8'h00}, {3'b100, 8'h80}, {3'b100, 8'h80}};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, t_op[i], t_a[i], t_k[i]);
            tick();
            drive(1'b0, 2'd0, 8'd0, 3'd0);
            checks++;
            if ({out_valid, out_n, out_z, out_c, out_result} !== {1'b1, t_e[i]}) begin
                errors++;
                $display("FAIL directed_%0d op=%0d a=%h k=%0d: got v=%b nzc=%b%b%b res=%h, want v=1 nzc=%b res=%h",
                         i, t_op[i], t_a[i], t_k[i], out_valid, out_n, out_z, out_c, out_result,
                         t_e[i][10:8], t_e[i][7:0]);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 8'h01, 3'd1);
        tick();
        drive(1'b1, 2'd0, 8'h01, 3'd2);
        tick();
        drive(1'b0, 2'd0, 8'h00, 3'd0);
        checks++;
        if ({in_ready, out_valid, out_result} !== {1'b0, 1'b1, 8'h02}) begin
            errors++;
            $display("FAIL bp_full: got rdy=%b v=%b res=%h, want rdy=0 v=1 res=02", in_ready, out_valid, out_result);
        end
        tick();
        checks++;
        if ({in_ready, out_valid, out_result} !== {1'b0, 1'b1, 8'h02}) begin
            errors++;
            $display("FAIL bp_hold: got rdy=%b v=%b res=%h, want rdy=0 v=1 res=02", in_ready, out_valid, out_result);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({in_ready, out_valid, out_result} !== {1'b1, 1'b1, 8'h04}) begin
            errors++;
            $display("FAIL bp_drain1: got rdy=%b v=%b res=%h, want rdy=1 v=1 res=04", in_ready, out_valid, out_result);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain2: got v=%b, want v=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        logic [7:0] a;
        logic [2:0] k;
        logic [10:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom_range(0, 255));
            k  = 3'($urandom_range(0, 7));
            exp = ref_model(op, a, k);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d: got rdy=%b, want 1", i, in_ready);
            end
            drive(1'b1, op, a, k);
            tick();
            checks++;
            if ({out_valid, out_n, out_z, out_c, out_result} !== {1'b1, exp}) begin
                errors++;
                $display("FAIL b2b_%0d op=%0d a=%h k=%0d: got v=%b nzc=%b%b%b res=%h, want v=1 nzc=%b res=%h",
                         i, op, a, k, out_valid, out_n, out_z, out_c, out_result, exp[10:8], exp[7:0]);
            end
        end
        drive(1'b0, 2'd0, 8'd0, 3'd0);
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: got v=%b, want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 8'h01, 3'd1);
        tick();
        drive(1'b1, 2'd0, 8'h01, 3'd2);
        tick();
        flush = 1'b1;
        drive(1'b1, 2'd0, 8'h03, 3'd1);
        tick();
        flush = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 3'd0);
        checks++;
        if ({out_valid, in_ready, out_result} !== {1'b0, 1'b1, 8'h02}) begin
            errors++;
            $display("FAIL flush_two: got v=%b rdy=%b res=%h, want v=0 rdy=1 res=02 (held)",
                     out_valid, in_ready, out_result);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_quiet_%0d: got v=%b res=%h, want v=0", i, out_valid, out_result);
            end
        end
        // Flush against an accepted input in ONE: the new op must vanish.
        out_ready = 1'b0;
        drive(1'b1, 2'd2, 8'h11, 3'd1);
        tick();
        flush = 1'b1;
        drive(1'b1, 2'd0, 8'h0F, 3'd4);
        tick();
        flush = 1'b0;
        drive(1'b0, 2'd0, 8'h00, 3'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({out_valid, in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL flush_one_%0d: got v=%b rdy=%b res=%h, want v=0 rdy=1", i, out_valid, in_ready, out_result);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [10:0] q[$];
        logic [1:0] op;
        logic [7:0] a;
        logic [2:0] k;
        logic in_fire, out_fire;
        for (int cyc = 0; cyc < 300; cyc++) begin
            checks++;
            if ({out_valid, in_ready} !== {q.size() != 0, q.size() < 2}) begin
                errors++;
                $display("FAIL rand_hs cyc=%0d: got v=%b rdy=%b, want v=%b rdy=%b",
                         cyc, out_valid, in_ready, q.size() != 0, q.size() < 2);
            end
            if (q.size() != 0) begin
                checks++;
                if ({out_n, out_z, out_c, out_result} !== q[0]) begin
                    errors++;
                    $display("FAIL rand_data cyc=%0d: got nzc=%b%b%b res=%h, want nzc=%b res=%h",
                             cyc, out_n, out_z, out_c, out_result, q[0][10:8], q[0][7:0]);
                end
            end
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom_range(0, 255));
            k  = 3'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 3) != 0), op, a, k);
            out_ready = 1'($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_fire   = in_valid & in_ready;
            out_fire  = out_valid & out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (out_fire) void'(q.pop_front());
                if (in_fire) q.push_back(ref_model(op, a, k));
            end
            tick();
        end
        flush = 1'b0;
        drive(1'b0, 2'd0, 8'd0, 3'd0);
    endtask

    task automatic test_async_reset();
        logic [10:0] exp;
        out_ready = 1'b0;
        drive(1'b1, 2'd3, 8'hC4, 3'd2);
        tick();
        drive(1'b0, 2'd0, 8'd0, 3'd0);
        tick();
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre: got v=%b, want 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_result, out_c, out_z, out_n} !== {1'b0, 1'b1, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL areset_now: got v=%b rdy=%b res=%h czn=%b%b%b, want v=0 rdy=1 res=00 czn=000",
                     out_valid, in_ready, out_result, out_c, out_z, out_n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        exp = ref_model(2'd1, 8'hB6, 3'd3);
        drive(1'b1, 2'd1, 8'hB6, 3'd3);
        tick();
        drive(1'b0, 2'd0, 8'd0, 3'd0);
        checks++;
        if ({out_valid, out_n, out_z, out_c, out_result} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL areset_post: got v=%b nzc=%b%b%b res=%h, want v=1 nzc=%b res=%h",
                     out_valid, out_n, out_z, out_c, out_result, exp[10:8], exp[7:0]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Registered execute-stage wrapper around the 8-bit combinational left barrel shifter in the datapath.
- Accepts a shift micro-op from decode over a valid/ready handshake and performs SHL, SHR, ROL or ASR.
- Registers the result with C/Z/N flags and presents them to write-back over a valid/ready handshake.
- A one-entry skid buffer keeps in_ready registered while sustaining full throughput.

Parameters:
- WIDTH, 8, data width; fixed at 8 for this processor. The amount width is log2(WIDTH) = 3.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; discards all held entries.
- in_valid  in  1  decode presents a micro-op.
- in_ready  out  1  stage can accept a micro-op.
- in_op  in  2  00 SHL, 01 SHR (logical), 10 ROL, 11 ASR.
- in_a  in  8  operand.
- in_amt  in  3  shift amount, 0..7.
- out_valid  out  1  result available to write-back.
- out_ready  in  1  write-back accepts the result.
- out_result  out  8  shifted value.
- out_c  out  1  carry flag: last bit shifted out.
- out_z  out  1  zero flag: out_result == 0.
- out_n  out  1  negative flag: out_result[7].

Behaviour:
- Reset, asynchronous on rst_n low:
  - out_valid = 0, in_ready = 1, out_result = 0, out_c = 0, out_z = 0, out_n = 0.
  - Skid buffer marked empty.
  - Any in-flight entry is lost. There is no recovery after rst_n rises.
- Transfers: input transfer on in_valid & in_ready at a clk edge; output transfer on out_valid & out_ready.
- Compute is combinational on the input side:
  - SHL: core left shift by in_amt.
  - SHR: bit-reverse in_a, left shift, bit-reverse the result.
  - ROL: (a << k) | (a >> (8-k)); k = 0 returns a unchanged.
  - ASR: as SHR, then bits [7:8-k] are replaced by a[7].
- Carry rules, k = in_amt:
  - If k = 0: C = 0 for every op.
  - SHL: C = a[8-k].
  - SHR and ASR: C = a[k-1].
  - ROL: C = result[0].
- Latency and throughput:
  - Exactly 1 cycle from input transfer to out_valid, when the output register is empty or draining.
  - Sustained rate is one op per cycle while out_ready = 1.
- Storage and state: output register (main) plus one skid entry. States:
  - EMPTY: main empty, skid empty.
  - ONE: main full, skid empty.
  - TWO: main full, skid full.
- State transitions (in = input transfer, out = output transfer):
  - EMPTY & in -> ONE.
  - ONE & in & !out -> TWO; the new op goes to skid.
  - ONE & in & out -> ONE; main is reloaded with the new op.
  - ONE & !in & out -> EMPTY.
  - TWO & out -> ONE; skid moves to main.
- in_ready = !(state == TWO), taken from a register, not combinational from out_ready. In TWO, in_ready = 0 and inputs are not sampled.
- Ordering is strictly FIFO. Output payload is stable while out_valid = 1 and out_ready = 0.
- Flush, synchronous:
  - Next state is EMPTY and out_valid = 0 next cycle; payload registers hold their values.
  - Flush wins over a simultaneous input transfer; that op is dropped.
  - Flush wins over a simultaneous output transfer; the transfer still counts as completed for write-back.
- Payload registers do not toggle when no transfer occurs (power).

Decomposition:
- Shared package holds:
  - Op encodings OP_SHL, OP_SHR, OP_ROL, OP_ASR.
  - DATA_W = 8, AMT_W = 3.
  - Flag bit indices shared with the ALU flag register.
- One sub-module, shift_core: the combinational op/amount -> result/flags function.
  - Instantiates the existing left-shifter for the shift.
  - Reverse wiring produces the right shifts.
  - Top level holds only the handshake state machine and the two registers.

Test Plan:
- SHL in_a = 0x81, in_amt = 1, out_ready = 1 -> next cycle out_valid = 1, result = 0x02, C = 1, Z = 0, N = 0.
- SHR 0x01 by 1 -> result 0x00, C = 1, Z = 1. ROL 0x81 by 3 -> result 0x0C, C = 0. ASR 0x80 by 7 -> result 0xFF, C = 0, N = 1. Any op with amt = 0 on 0x5A -> result 0x5A, C = 0.
- Backpressure: out_ready = 0; send SHL 0x01 by 1 and then SHL 0x01 by 2 -> in_ready = 0 after the second. Raise out_ready -> results 0x02 then 0x04, in order, with no duplicates. in_ready = 1 again the cycle after the first drain.
- Back-to-back streaming: 8 ops on consecutive cycles with out_ready = 1 -> 8 results on consecutive cycles, in_ready never drops.
- Flush in state TWO, with a valid input on the same cycle -> next cycle out_valid = 0 and in_ready = 1; the dropped op never appears.
- Assert rst_n low mid-stream while out_valid = 1 -> out_valid = 0 immediately, without waiting for clk. After release, the first new op returns its correct result after 1 cycle.
